// File: rtl/blur_rd_arbiter.sv
// Round-robin arbiter sharing the blurred-image read port and line-buffer write path
// between two row-burst requesters.
module blur_rd_arbiter #(
   parameter int ADDR_W = 9,
   parameter int LEN_W  = 5,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [LEN_W-1:0]  req0_len,
   input  logic              req0_layer,
   output logic              gnt0,
   output logic              done0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [LEN_W-1:0]  req1_len,
   input  logic              req1_layer,
   output logic              gnt1,
   output logic              done1,
   output logic              mem_re,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              readFrom,
   output logic              LB_WE,
   output logic              lb_sel,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t              state_q;
   logic                last_gnt_q;
   logic                owner_q;
   logic [LEN_W-1:0]    rem_q;
   logic                gnt0_q, gnt1_q;
   logic                mem_re_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic                read_from_q;
   logic                busy_q;
   logic                zpend_q, zdone0_q, zdone1_q;
   logic [RD_LAT-1:0]   we_pipe_q, sel_pipe_q, last0_pipe_q, last1_pipe_q;

   logic                pick1_d, grant_d;
   logic [ADDR_W-1:0]   g_addr_d;
   logic [LEN_W-1:0]    g_len_d;
   logic                g_layer_d;
   logic                last_row_d;
   logic [RD_LAT:0]     we_chain_d, sel_chain_d, last0_chain_d, last1_chain_d;

   always_comb begin
      grant_d   = req0 | req1;
      pick1_d   = req1 & (~req0 | ~last_gnt_q);
      g_addr_d  = pick1_d ? req1_addr  : req0_addr;
      g_len_d   = pick1_d ? req1_len   : req0_len;
      g_layer_d = pick1_d ? req1_layer : req0_layer;
   end

   // Write-enable, owner and last-row markers ride the same RD_LAT-deep delay line,
   // so done lands exactly on the final LB_WE.
   assign last_row_d    = mem_re_q & (rem_q == '0);
   assign we_chain_d    = {we_pipe_q,    mem_re_q};
   assign sel_chain_d   = {sel_pipe_q,   mem_re_q & owner_q};
   assign last0_chain_d = {last0_pipe_q, last_row_d & ~owner_q};
   assign last1_chain_d = {last1_pipe_q, last_row_d & owner_q};

   assign gnt0     = gnt0_q;
   assign gnt1     = gnt1_q;
   assign done0    = last0_pipe_q[RD_LAT-1] | zdone0_q;
   assign done1    = last1_pipe_q[RD_LAT-1] | zdone1_q;
   assign mem_re   = mem_re_q;
   assign mem_addr = mem_addr_q;
   assign readFrom = read_from_q;
   assign LB_WE    = we_pipe_q[RD_LAT-1];
   assign lb_sel   = sel_pipe_q[RD_LAT-1];
   assign busy     = busy_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_gnt_q   <= 1'b1;
         owner_q      <= 1'b0;
         rem_q        <= '0;
         gnt0_q       <= 1'b0;
         gnt1_q       <= 1'b0;
         mem_re_q     <= 1'b0;
         mem_addr_q   <= '0;
         read_from_q  <= 1'b0;
         busy_q       <= 1'b0;
         zpend_q      <= 1'b0;
         zdone0_q     <= 1'b0;
         zdone1_q     <= 1'b0;
         we_pipe_q    <= '0;
         sel_pipe_q   <= '0;
         last0_pipe_q <= '0;
         last1_pipe_q <= '0;
      end else begin
         gnt0_q       <= 1'b0;
         gnt1_q       <= 1'b0;
         we_pipe_q    <= we_chain_d[RD_LAT-1:0];
         sel_pipe_q   <= sel_chain_d[RD_LAT-1:0];
         last0_pipe_q <= last0_chain_d[RD_LAT-1:0];
         last1_pipe_q <= last1_chain_d[RD_LAT-1:0];
         // Zero-length bursts skip the delay line and report done one cycle after grant.
         zdone0_q     <= zpend_q & ~owner_q;
         zdone1_q     <= zpend_q & owner_q;
         zpend_q      <= 1'b0;
         case (state_q)
            IDLE: begin
               if (grant_d) begin
                  gnt0_q      <= ~pick1_d;
                  gnt1_q      <= pick1_d;
                  last_gnt_q  <= pick1_d;
                  owner_q     <= pick1_d;
                  read_from_q <= g_layer_d;
                  busy_q      <= 1'b1;
                  if (g_len_d == '0) begin
                     zpend_q <= 1'b1;
                     state_q <= DRAIN;
                  end else begin
                     mem_re_q   <= 1'b1;
                     mem_addr_q <= g_addr_d;
                     rem_q      <= g_len_d - LEN_W'(1);
                     state_q    <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (rem_q == '0) begin
                  mem_re_q <= 1'b0;
                  state_q  <= DRAIN;
               end else begin
                  mem_addr_q <= mem_addr_q + ADDR_W'(1);
                  rem_q      <= rem_q - LEN_W'(1);
               end
            end
            DRAIN: begin
               if (done0 | done1) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_blur_rd_arbiter.sv
// Bench for blur_rd_arbiter: RD_LAT=1 and RD_LAT=3 instances share stimulus and are
// checked every cycle against a burst-schedule model, plus directed vectors.
module tb_blur_rd_arbiter;
   localparam int AW = 9;
   localparam int LW = 5;
   localparam int NC = 4096;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          req0 = 0, req1 = 0, ly0 = 0, ly1 = 0;
   logic [AW-1:0] a0 = '0, a1 = '0;
   logic [LW-1:0] l0 = '0, l1 = '0;

   logic          gnt0_w[2], gnt1_w[2], done0_w[2], done1_w[2];
   logic          re_w[2], rf_w[2], we_w[2], sel_w[2], busy_w[2];
   logic [AW-1:0] addr_w[2];

   blur_rd_arbiter #(.ADDR_W(AW), .LEN_W(LW), .RD_LAT(1)) u_lat1 (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req0_addr(a0), .req0_len(l0), .req0_layer(ly0),
      .gnt0(gnt0_w[0]), .done0(done0_w[0]),
      .req1(req1), .req1_addr(a1), .req1_len(l1), .req1_layer(ly1),
      .gnt1(gnt1_w[0]), .done1(done1_w[0]),
      .mem_re(re_w[0]), .mem_addr(addr_w[0]), .readFrom(rf_w[0]),
      .LB_WE(we_w[0]), .lb_sel(sel_w[0]), .busy(busy_w[0]));

   blur_rd_arbiter #(.ADDR_W(AW), .LEN_W(LW), .RD_LAT(3)) u_lat3 (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req0_addr(a0), .req0_len(l0), .req0_layer(ly0),
      .gnt0(gnt0_w[1]), .done0(done0_w[1]),
      .req1(req1), .req1_addr(a1), .req1_len(l1), .req1_layer(ly1),
      .gnt1(gnt1_w[1]), .done1(done1_w[1]),
      .mem_re(re_w[1]), .mem_addr(addr_w[1]), .readFrom(rf_w[1]),
      .LB_WE(we_w[1]), .lb_sel(sel_w[1]), .busy(busy_w[1]));

   typedef struct packed {
      logic          gnt0, gnt1, done0, done1, re;
      logic [AW-1:0] addr;
      logic          rf, we, sel, busy;
   } exp_t;

   exp_t ex[2][NC];
   int   cyc = 0;
   int   free_at[2];
   bit   last[2];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", nm, d, cyc, act, expv);
      end
   endtask

   // Reference model: each grant writes the whole expected burst timeline into ex[].
   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int i = cyc; i < NC; i++) ex[d][i] = '0;
         free_at[d] = 0;
         last[d] = 1'b1;
      end
   endtask

   task automatic schedule(int d, int c, bit own, logic [AW-1:0] addr, int len, bit lay);
      int lat = (d == 1) ? 3 : 1;
      int g = c + 1;
      int dn = (len == 0) ? c + 2 : c + len + lat;
      if (dn + 2 >= NC) return;
      if (own) ex[d][g].gnt1 = 1'b1; else ex[d][g].gnt0 = 1'b1;
      for (int k = 0; k < len; k++) begin
         ex[d][g+k].re = 1'b1;
         ex[d][g+k].addr = AW'((int'(addr) + k) % (1 << AW));
         ex[d][g+k+lat].we = 1'b1;
         ex[d][g+k+lat].sel = own;
      end
      if (own) ex[d][dn].done1 = 1'b1; else ex[d][dn].done0 = 1'b1;
      for (int i = g; i <= dn; i++) ex[d][i].busy = 1'b1;
      for (int i = g; i < NC; i++) ex[d][i].rf = lay;
      free_at[d] = dn + 1;
      last[d] = own;
   endtask

   always @(negedge rst_n) model_reset();

   always @(posedge clk) begin
      if (rst_n) begin
         for (int d = 0; d < 2; d++) begin
            if (cyc >= free_at[d] && (req0 || req1)) begin
               bit w1;
               w1 = req1 && (!req0 || !last[d]);
               if (w1) schedule(d, cyc, 1'b1, a1, int'(l1), ly1);
               else    schedule(d, cyc, 1'b0, a0, int'(l0), ly0);
            end
         end
      end
      cyc++;
   end

   always @(negedge clk) begin
      if (cyc < NC) begin
         for (int d = 0; d < 2; d++) begin
            exp_t e;
            e = ex[d][cyc];
            chk("gnt0",  d, 32'(gnt0_w[d]),  32'(e.gnt0));
            chk("gnt1",  d, 32'(gnt1_w[d]),  32'(e.gnt1));
            chk("done0", d, 32'(done0_w[d]), 32'(e.done0));
            chk("done1", d, 32'(done1_w[d]), 32'(e.done1));
            chk("mem_re", d, 32'(re_w[d]),   32'(e.re));
            if (e.re) chk("mem_addr", d, 32'(addr_w[d]), 32'(e.addr));
            chk("readFrom", d, 32'(rf_w[d]), 32'(e.rf));
            chk("LB_WE", d, 32'(we_w[d]),   32'(e.we));
            chk("lb_sel", d, 32'(sel_w[d]), 32'(e.sel));
            chk("busy",  d, 32'(busy_w[d]), 32'(e.busy));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic sig(int d, int k);
      case (k)
         0: return gnt0_w[d];
         1: return gnt1_w[d];
         2: return done0_w[d];
         default: return done1_w[d];
      endcase
   endfunction

   task automatic wait_sig(int d, int k, int bound, string nm, output int at);
      at = -1;
      for (int i = 0; i < bound; i++) begin
         step();
         if (sig(d, k)) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) chk({nm, "_timeout"}, d, 32'd0, 32'd1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy_w[0] || busy_w[1]) && n < 80) begin
         step();
         n++;
      end
      if (busy_w[0] || busy_w[1]) chk("idle_timeout", 0, 32'd0, 32'd1);
   endtask

   typedef struct {
      bit r0, r1;
      logic [AW-1:0] a0, a1;
      logic [LW-1:0] l0, l1;
      bit ly0, ly1;
      bit own;
      int nre, ofs1, ofs3;
   } vec_t;

   vec_t vt[7];

   initial begin
      int g, d0, g1, d1, ofs1, ofs3, nre;
      bit own;
      model_reset();

      vt[0] = '{1, 0, 9'd100, 9'd0,   5'd17, 5'd0, 1, 0, 0, 17, 17, 19};
      vt[1] = '{0, 1, 9'd0,   9'd508, 5'd0,  5'd8, 0, 0, 1, 8,  8,  10};
      vt[2] = '{1, 0, 9'd7,   9'd0,   5'd0,  5'd0, 1, 0, 0, 0,  1,  1};
      vt[3] = '{1, 1, 9'd5,   9'd20,  5'd3,  5'd4, 0, 1, 1, 4,  4,  6};
      vt[4] = '{1, 1, 9'd40,  9'd60,  5'd3,  5'd2, 1, 0, 0, 3,  3,  5};
      vt[5] = '{0, 1, 9'd0,   9'd511, 5'd0,  5'd1, 0, 1, 1, 1,  1,  3};
      vt[6] = '{1, 0, 9'd480, 9'd0,   5'd31, 5'd0, 0, 0, 0, 31, 31, 33};

      // Tie out of reset, then round-robin with both requests held.
      step(); step(); step();
      a0 = 9'd10; l0 = 5'd2; ly0 = 1'b0;
      a1 = 9'd200; l1 = 5'd3; ly1 = 1'b1;
      req0 = 1'b1; req1 = 1'b1;
      rst_n = 1'b1;
      wait_sig(0, 0, 5, "tie_gnt0", g);
      chk("tie_gnt1_low", 0, 32'(gnt1_w[0]), 32'd0);
      wait_sig(0, 2, 20, "rr_done0", d0);
      wait_sig(0, 1, 10, "rr_gnt1", g1);
      chk("rr_gnt1_gap", 0, 32'(g1 - d0), 32'd2);
      req1 = 1'b0;
      wait_sig(0, 3, 20, "rr_done1", d1);
      wait_sig(0, 0, 10, "rr_gnt0", g);
      chk("rr_gnt0_gap", 0, 32'(g - d1), 32'd2);
      req0 = 1'b0;
      wait_idle();

      // Asynchronous reset in the middle of a 17-row burst.
      a0 = 9'd100; l0 = 5'd17; ly0 = 1'b1; req0 = 1'b1;
      wait_sig(0, 0, 5, "rst_gnt", g);
      req0 = 1'b0;
      for (int i = 0; i < 4; i++) step();
      #2 rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("rst_mem_re", d, 32'(re_w[d]), 32'd0);
         chk("rst_LB_WE",  d, 32'(we_w[d]), 32'd0);
         chk("rst_busy",   d, 32'(busy_w[d]), 32'd0);
         chk("rst_readFrom", d, 32'(rf_w[d]), 32'd0);
         chk("rst_mem_addr", d, 32'(addr_w[d]), 32'd0);
         chk("rst_done", d, 32'(done0_w[d] | done1_w[d]), 32'd0);
      end
      step(); step();
      rst_n = 1'b1;
      l0 = 5'd1; l1 = 5'd1; req0 = 1'b1; req1 = 1'b1;
      wait_sig(0, 0, 4, "post_rst_gnt0", g);
      chk("post_rst_gnt1_low", 0, 32'(gnt1_w[0]), 32'd0);
      req0 = 1'b0; req1 = 1'b0;
      wait_idle();

      // Directed vectors.
      foreach (vt[v]) begin
         wait_idle();
         req0 = vt[v].r0; req1 = vt[v].r1;
         a0 = vt[v].a0; a1 = vt[v].a1; l0 = vt[v].l0; l1 = vt[v].l1;
         ly0 = vt[v].ly0; ly1 = vt[v].ly1;
         g = -1;
         for (int i = 0; i < 4 && g < 0; i++) begin
            step();
            if (gnt0_w[0] || gnt1_w[0]) g = cyc;
         end
         if (g < 0) chk("vec_gnt_timeout", v, 32'd0, 32'd1);
         own = gnt1_w[0];
         chk("vec_owner", v, 32'(own), 32'(vt[v].own));
         chk("vec_owner_lat3", v, 32'(gnt1_w[1]), 32'(vt[v].own));
         req0 = 1'b0; req1 = 1'b0;
         nre = 0; ofs1 = -1; ofs3 = -1;
         for (int t = 0; t < 40; t++) begin
            if (re_w[0]) nre++;
            if ((done0_w[0] || done1_w[0]) && ofs1 < 0) ofs1 = t;
            if ((done0_w[1] || done1_w[1]) && ofs3 < 0) ofs3 = t;
            step();
         end
         chk("vec_nre",  v, 32'(nre),  32'(vt[v].nre));
         chk("vec_done_ofs_lat1", v, 32'(ofs1), 32'(vt[v].ofs1));
         chk("vec_done_ofs_lat3", v, 32'(ofs3), 32'(vt[v].ofs3));
      end

      // Random traffic against the model.
      wait_idle();
      for (int i = 0; i < 1500; i++) begin
         step();
         if (req0 && (gnt0_w[0] || $urandom_range(0, 15) == 0)) req0 = 1'b0;
         else if (!req0 && $urandom_range(0, 3) == 0) begin
            req0 = 1'b1;
            a0 = ($urandom_range(0, 2) == 0) ? AW'($urandom_range(500, 511)) : AW'($urandom);
            l0 = ($urandom_range(0, 5) == 0) ? LW'($urandom) : LW'($urandom_range(0, 6));
            ly0 = 1'($urandom);
         end
         if (req1 && (gnt1_w[0] || $urandom_range(0, 15) == 0)) req1 = 1'b0;
         else if (!req1 && $urandom_range(0, 3) == 0) begin
            req1 = 1'b1;
            a1 = ($urandom_range(0, 2) == 0) ? AW'($urandom_range(500, 511)) : AW'($urandom);
            l1 = ($urandom_range(0, 5) == 0) ? LW'($urandom) : LW'($urandom_range(0, 6));
            ly1 = 1'($urandom);
         end
      end
      req0 = 1'b0; req1 = 1'b0;
      wait_idle();
      step(); step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
